// File: rtl/lag_scan_sequencer.sv
// lag_scan_sequencer
//   Per-channel lag sweep controller. Each channel ramps its lag from a
//   start value towards end = min(start+len, 2^LAG_WIDTH-1) in steps of inc,
//   in one of three scan modes (one-shot, wrap, bounce), and publishes a
//   registered, saturated period word (lag * TICK_CYCLES) for the sampling
//   clock generators.
//
// Ports
//   pllclk        sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   load          reload every channel from start (wins over step)
//   step          advance enabled channels by one increment
//   mode          0 ONE_SHOT, 1 WRAP, 2 BOUNCE, 3 HOLD
//   chan_en       per-channel step enable
//   start_a/len_a/inc_a   packed per-channel scan configuration
//   lag_a         current lag per channel
//   period_a      saturated lag*TICK_CYCLES, one cycle behind lag_a
//   done          sticky one-shot completion flag per channel
//   wrapped       one-cycle pulse on wrap restart / bounce return
//
// Optional build macro
//   LAG_SCAN_STEP_COUNT_EN  adds step_count_a: per-channel 16-bit saturating
//                           count of accepted steps since the last load.
module lag_scan_sequencer #(
    parameter int NUM_CHANNELS = 8,
    parameter int LAG_WIDTH    = 20,
    parameter int INC_WIDTH    = 12,
    parameter int TICK_CYCLES  = 2,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                                 pllclk,
    input  logic                                 reset_n,
    input  logic                                 load,
    input  logic                                 step,
    input  logic [1:0]                           mode,
    input  logic [NUM_CHANNELS-1:0]              chan_en,
    input  logic [NUM_CHANNELS*LAG_WIDTH-1:0]    start_a,
    input  logic [NUM_CHANNELS*LAG_WIDTH-1:0]    len_a,
    input  logic [NUM_CHANNELS*INC_WIDTH-1:0]    inc_a,
    output logic [NUM_CHANNELS*LAG_WIDTH-1:0]    lag_a,
    output logic [NUM_CHANNELS*PERIOD_WIDTH-1:0] period_a,
    output logic [NUM_CHANNELS-1:0]              done,
    output logic [NUM_CHANNELS-1:0]              wrapped
`ifdef LAG_SCAN_STEP_COUNT_EN
    ,
    output logic [NUM_CHANNELS*16-1:0]           step_count_a
`endif
);

    // One extra bit so start+len and lag+/-inc never wrap silently.
    localparam int EW      = LAG_WIDTH + 1;
    localparam int PW_FULL = LAG_WIDTH + 32;
    localparam logic [EW-1:0] LAG_MAX = {1'b0, {LAG_WIDTH{1'b1}}};

    localparam logic [1:0] M_ONE_SHOT = 2'd0;
    localparam logic [1:0] M_WRAP     = 2'd1;
    localparam logic [1:0] M_BOUNCE   = 2'd2;
    localparam logic [1:0] M_HOLD     = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [PERIOD_WIDTH-1:0] sat_period(input logic [LAG_WIDTH-1:0] lag);
        logic [PW_FULL-1:0] prod;
        prod = PW_FULL'(lag) * PW_FULL'(TICK_CYCLES);
        if (|prod[PW_FULL-1:PERIOD_WIDTH])
            return {PERIOD_WIDTH{1'b1}};
        return prod[PERIOD_WIDTH-1:0];
    endfunction

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [LAG_WIDTH-1:0]    w_start;
        logic [LAG_WIDTH-1:0]    w_len;
        logic [INC_WIDTH-1:0]    w_inc;
        logic [EW-1:0]           w_sum;
        logic [LAG_WIDTH-1:0]    w_end;
        logic [EW-1:0]           w_next_up;
        logic [EW-1:0]           w_next_dn;
        logic                    w_step_ok;
        state_t                  r_state;
        state_t                  w_state_nx;
        logic [LAG_WIDTH-1:0]    r_lag;
        logic [LAG_WIDTH-1:0]    w_lag_nx;
        logic                    r_done;
        logic                    w_done_nx;
        logic                    r_wrapped;
        logic                    w_wrapped_nx;
        logic [PERIOD_WIDTH-1:0] r_period;

        assign w_start   = start_a[g*LAG_WIDTH +: LAG_WIDTH];
        assign w_len     = len_a[g*LAG_WIDTH +: LAG_WIDTH];
        assign w_inc     = inc_a[g*INC_WIDTH +: INC_WIDTH];
        assign w_sum     = {1'b0, w_start} + {1'b0, w_len};
        assign w_end     = (w_sum > LAG_MAX) ? {LAG_WIDTH{1'b1}} : w_sum[LAG_WIDTH-1:0];
        assign w_next_up = {1'b0, r_lag} + EW'(w_inc);
        assign w_next_dn = {1'b0, r_lag} - EW'(w_inc);

        // A zero increment is a no-op so it never trips end-of-range actions.
        assign w_step_ok = step && chan_en[g] && (mode != M_HOLD) &&
                           ((r_state == S_UP) || (r_state == S_DOWN)) &&
                           (w_inc != '0);

        always_comb begin
            w_state_nx   = r_state;
            w_lag_nx     = r_lag;
            w_done_nx    = r_done;
            w_wrapped_nx = 1'b0;
            if (load) begin
                w_lag_nx   = w_start;
                w_state_nx = S_UP;
                w_done_nx  = 1'b0;
            end else if (w_step_ok) begin
                case (mode)
                    M_ONE_SHOT: begin
                        if (w_next_up >= {1'b0, w_end}) begin
                            w_lag_nx   = w_end;
                            w_state_nx = S_DONE;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_lag_nx   = w_next_up[LAG_WIDTH-1:0];
                            w_state_nx = S_UP;
                        end
                    end
                    M_WRAP: begin
                        w_state_nx = S_UP;
                        if (w_next_up > {1'b0, w_end}) begin
                            w_lag_nx     = w_start;
                            w_wrapped_nx = 1'b1;
                        end else begin
                            w_lag_nx = w_next_up[LAG_WIDTH-1:0];
                        end
                    end
                    M_BOUNCE: begin
                        if (r_state == S_UP) begin
                            if (w_next_up >= {1'b0, w_end}) begin
                                w_lag_nx   = w_end;
                                w_state_nx = S_DOWN;
                            end else begin
                                w_lag_nx = w_next_up[LAG_WIDTH-1:0];
                            end
                        end else begin
                            // MSB set means lag-inc borrowed below zero.
                            if (w_next_dn[LAG_WIDTH] ||
                                (w_next_dn[LAG_WIDTH-1:0] <= w_start)) begin
                                w_lag_nx     = w_start;
                                w_state_nx   = S_UP;
                                w_wrapped_nx = 1'b1;
                            end else begin
                                w_lag_nx = w_next_dn[LAG_WIDTH-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge pllclk or negedge reset_n) begin
            if (!reset_n) begin
                r_state   <= S_IDLE;
                r_lag     <= '0;
                r_done    <= 1'b0;
                r_wrapped <= 1'b0;
                r_period  <= '0;
            end else begin
                r_state   <= w_state_nx;
                r_lag     <= w_lag_nx;
                r_done    <= w_done_nx;
                r_wrapped <= w_wrapped_nx;
                r_period  <= sat_period(r_lag);
            end
        end

        assign lag_a[g*LAG_WIDTH +: LAG_WIDTH]          = r_lag;
        assign period_a[g*PERIOD_WIDTH +: PERIOD_WIDTH] = r_period;
        assign done[g]                                  = r_done;
        assign wrapped[g]                               = r_wrapped;

`ifdef LAG_SCAN_STEP_COUNT_EN
        logic [15:0] r_step_cnt;
        logic        w_accept;

        assign w_accept = w_step_ok && !load &&
                          ((w_lag_nx != r_lag) || (w_state_nx != r_state));

        always_ff @(posedge pllclk or negedge reset_n) begin
            if (!reset_n)
                r_step_cnt <= '0;
            else if (load)
                r_step_cnt <= '0;
            else if (w_accept && (r_step_cnt != 16'hFFFF))
                r_step_cnt <= r_step_cnt + 16'd1;
        end

        assign step_count_a[g*16 +: 16] = r_step_cnt;
`endif
    end

endmodule

// File: doc/lag_scan_sequencer.md
Name: lag_scan_sequencer

Overview:
- Per-channel lag sweep controller that generates the sampling-period words feeding the auto and cross sampling clock generators.
- It generalises the fixed per-line start/length/increment ramp to:
  - a configurable number of channels and lag width;
  - three scan modes (one-shot, wrap, bounce);
  - per-channel enables, saturating end-of-range arithmetic, and registered period output.
- It sits between the command parser (start/len/inc) and the CLK_GEN instances, stepped by the packet-done strobe.

Parameters:
- NUM_CHANNELS, 8: number of independent lag channels.
- LAG_WIDTH, 20: width of start, length and current lag.
- INC_WIDTH, 12: width of per-channel increment.
- TICK_CYCLES, 2: multiplier applied to lag to form the period word.
- PERIOD_WIDTH, 24: width of each period output; saturating.

Ports:
- pllclk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle pulse; reloads every channel from start.
- step  in  1  single-cycle pulse; advances enabled channels one step.
- mode  in  2  0=ONE_SHOT, 1=WRAP, 2=BOUNCE, 3=HOLD; global, sampled on step.
- chan_en  in  NUM_CHANNELS  per-channel step enable.
- start_a  in  NUM_CHANNELS*LAG_WIDTH  per-channel scan start.
- len_a  in  NUM_CHANNELS*LAG_WIDTH  per-channel scan length.
- inc_a  in  NUM_CHANNELS*INC_WIDTH  per-channel step increment.
- lag_a  out  NUM_CHANNELS*LAG_WIDTH  current lag per channel.
- period_a  out  NUM_CHANNELS*PERIOD_WIDTH  TICK_CYCLES*lag, registered.
- done  out  NUM_CHANNELS  ONE_SHOT scan finished; sticky until load.
- wrapped  out  NUM_CHANNELS  one-cycle pulse on WRAP restart or BOUNCE return to start.

Behaviour:
- Reset (async, reset_n=0):
  - lag_a=0, period_a=0, done=0, wrapped=0;
  - every channel FSM in IDLE.
- Per-channel FSM states: IDLE, UP, DOWN, DONE.
- end = min(start+len, 2^LAG_WIDTH-1); the sum is computed in LAG_WIDTH+1 bits.
- next_up = lag+inc and next_dn = lag-inc, both computed in LAG_WIDTH+1 bits (no silent wrap).
- load: all channels, regardless of chan_en:
  - lag<=start, state<=UP, done<=0;
  - visible on lag_a the cycle after load.
- step, per channel, only if chan_en=1, state in {UP, DOWN} and mode!=HOLD:
  - ONE_SHOT:
    - next_up>=end: lag<=end, state<=DONE, done<=1;
    - else lag<=next_up.
  - WRAP:
    - next_up>end: lag<=start, wrapped pulse;
    - else lag<=next_up.
  - BOUNCE, UP:
    - next_up>=end: lag<=end, state<=DOWN;
    - else lag<=next_up.
  - BOUNCE, DOWN:
    - next_dn<=start (including borrow): lag<=start, state<=UP, wrapped pulse;
    - else lag<=next_dn.
- Steps in IDLE or DONE are ignored.
- Channels with chan_en=0 hold lag and state.
- mode=HOLD: step ignored entirely; state preserved.
- DOWN state under a non-BOUNCE mode is treated as UP on the next step.
- inc=0: lag unchanged, no state change, no pulses.
- len=0: end=start.
  - ONE_SHOT: first step sets done.
  - WRAP: every step pulses wrapped.
- load and step in the same cycle: load wins; step discarded.
- wrapped: high exactly one cycle after the causing step; otherwise 0.
- period_a:
  - registered one cycle after lag_a, i.e. 2 cycles after load/step;
  - value = lag*TICK_CYCLES;
  - saturates to 2^PERIOD_WIDTH-1 on overflow.
- Channels are fully independent; no cross-channel arbitration.
- reset_n asserted mid-scan: immediate return to reset values; the next load restarts.

Optional Feature:
- Macro: LAG_SCAN_STEP_COUNT_EN.
- Defined:
  - adds output step_count_a, NUM_CHANNELS*16;
  - counts accepted steps (those that changed lag or state) per channel since the last load;
  - cleared by load and reset;
  - saturates at 16'hFFFF.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset then load, ch0 start=10 len=5 inc=2, mode=ONE_SHOT, 3 steps:
  - lag 10→12→14→15;
  - done[0]=1 after third step;
  - fourth step leaves lag=15;
  - period=30 two cycles after the last lag change.
- WRAP, start=0 len=4 inc=3:
  - steps give lag 3, 0 (wrapped pulse exactly 1 cycle), 3;
  - no done.
- BOUNCE, start=2 len=6 inc=4:
  - lag 6, 8 (DOWN), 4, 2 (wrapped pulse), 6.
- load and step same cycle after lag=6:
  - lag=start next cycle; no step applied.
  - chan_en[1]=0: ch1 lag frozen while ch0 advances.
- Saturation:
  - LAG_WIDTH=20, start=20'hFFFF0 len=20'h100 inc=12'h020, ONE_SHOT: end clamps to 20'hFFFFF; one step → done.
  - TICK_CYCLES=2, PERIOD_WIDTH=20: period_a saturates to 20'hFFFFF.
- Async reset mid-BOUNCE (state DOWN):
  - outputs 0 immediately, before next edge;
  - steps ignored until load.
  - With LAG_SCAN_STEP_COUNT_EN: step_count reads 0 after reset, increments per accepted step.
